copro_issue_sched: RTL and testbench

- In-order issue scheduler that sits between the CV-X-IF offload front-end and the single-cycle coprocessor ALU.
- Buffers decoded offload requests in an instruction queue (IQ) and issues at most one op per cycle to the ALU.
- The ALU has no stall input, so issue is credit-gated: every ALU result is guaranteed a free slot in the result queue (RQ).
- The RQ drains to the core's result interface under a valid/ready handshake.

---
 rtl/copro_issue_sched.sv | 200 ++++++++++++++++++++
 tb/tb_copro_issue_sched.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/copro_issue_sched.sv
// In-order issue scheduler between the CV-X-IF offload front-end and the single-cycle ALU.
// Issue is credit-gated: an op only leaves the IQ when its result is sure of an RQ slot.
module copro_issue_sched #(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     NrRgprPorts = 2,
   parameter int unsigned     OP_W        = 4,
   parameter int unsigned     ID_W        = 4,
   parameter int unsigned     HART_W      = 1,
   parameter int unsigned     IQ_DEPTH    = 4,
   parameter int unsigned     RQ_DEPTH    = 2,
   parameter logic [OP_W-1:0] IDLE_OP     = 4'hF
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [OP_W-1:0]             req_opcode_i,
   input  logic [NrRgprPorts*XLEN-1:0] req_rs_i,
   input  logic [4:0]                  req_rd_i,
   input  logic [5:0]                  req_imm_i,
   input  logic [ID_W-1:0]             req_id_i,
   input  logic [HART_W-1:0]           req_hartid_i,
   output logic [OP_W-1:0]             alu_opcode_o,
   output logic [NrRgprPorts*XLEN-1:0] alu_rs_o,
   output logic [4:0]                  alu_rd_o,
   output logic [5:0]                  alu_imm_o,
   output logic [ID_W-1:0]             alu_id_o,
   output logic [HART_W-1:0]           alu_hartid_o,
   input  logic                        alu_valid_i,
   input  logic [XLEN-1:0]             alu_result_i,
   input  logic [4:0]                  alu_rd_i,
   input  logic                        alu_we_i,
   input  logic [ID_W-1:0]             alu_id_i,
   input  logic [HART_W-1:0]           alu_hartid_i,
   output logic                        res_valid_o,
   input  logic                        res_ready_i,
   output logic [XLEN-1:0]             res_data_o,
   output logic [4:0]                  res_rd_o,
   output logic                        res_we_o,
   output logic [ID_W-1:0]             res_id_o,
   output logic [HART_W-1:0]           res_hartid_o,
   output logic                        busy_o,
   output logic                        drop_o
);

   localparam int unsigned RsW    = NrRgprPorts * XLEN;
   localparam int unsigned IqPtrW = $clog2(IQ_DEPTH);
   localparam int unsigned RqPtrW = $clog2(RQ_DEPTH);

   logic [OP_W-1:0]   iq_op_q   [IQ_DEPTH];
   logic [RsW-1:0]    iq_rs_q   [IQ_DEPTH];
   logic [4:0]        iq_rd_q   [IQ_DEPTH];
   logic [5:0]        iq_imm_q  [IQ_DEPTH];
   logic [ID_W-1:0]   iq_id_q   [IQ_DEPTH];
   logic [HART_W-1:0] iq_hart_q [IQ_DEPTH];
   logic [IqPtrW-1:0] iq_wptr_q, iq_wptr_d, iq_rptr_q, iq_rptr_d;
   logic [IqPtrW:0]   iq_cnt_q, iq_cnt_d;

   logic [XLEN-1:0]   rq_data_q [RQ_DEPTH];
   logic [4:0]        rq_rd_q   [RQ_DEPTH];
   logic              rq_we_q   [RQ_DEPTH];
   logic [ID_W-1:0]   rq_id_q   [RQ_DEPTH];
   logic [HART_W-1:0] rq_hart_q [RQ_DEPTH];
   logic [RqPtrW-1:0] rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
   logic [RqPtrW:0]   rq_cnt_q, rq_cnt_d;

   logic              inflight_q, inflight_d;
   logic              iq_empty, iq_full, rq_empty, rq_full;
   logic              iq_push, iq_pop, rq_push, rq_pop, issue;
   logic [RqPtrW+1:0] rq_used;

   assign iq_empty    = (iq_cnt_q == '0);
   assign iq_full     = (iq_cnt_q == (IqPtrW+1)'(IQ_DEPTH));
   assign rq_empty    = (rq_cnt_q == '0);
   assign rq_full     = (rq_cnt_q == (RqPtrW+1)'(RQ_DEPTH));

   assign req_ready_o = !iq_full && !flush_i;
   assign iq_push     = req_valid_i && req_ready_o;
   assign rq_pop      = !rq_empty && res_ready_i;

   // Slots committed to results next cycle: occupancy plus the op in the ALU, minus this pop.
   assign rq_used = {1'b0, rq_cnt_q} + {{(RqPtrW+1){1'b0}}, inflight_q}
                    - {{(RqPtrW+1){1'b0}}, rq_pop};
   assign issue   = !iq_empty && !flush_i && (rq_used < (RqPtrW+2)'(RQ_DEPTH));
   assign iq_pop  = issue;

   // A result landing during a flush is discarded silently.
   assign rq_push    = inflight_q && alu_valid_i && !flush_i;
   assign drop_o     = inflight_q && !alu_valid_i && !flush_i;
   assign inflight_d = issue;
   assign busy_o     = !iq_empty || inflight_q || !rq_empty;

   always_comb begin
      iq_wptr_d = iq_wptr_q;
      iq_rptr_d = iq_rptr_q;
      iq_cnt_d  = iq_cnt_q;
      if (flush_i) begin
         iq_wptr_d = '0;
         iq_rptr_d = '0;
         iq_cnt_d  = '0;
      end else begin
         if (iq_push) iq_wptr_d = iq_wptr_q + IqPtrW'(1);
         if (iq_pop)  iq_rptr_d = iq_rptr_q + IqPtrW'(1);
         case ({iq_push, iq_pop})
            2'b10:   iq_cnt_d = iq_cnt_q + (IqPtrW+1)'(1);
            2'b01:   iq_cnt_d = iq_cnt_q - (IqPtrW+1)'(1);
            default: iq_cnt_d = iq_cnt_q;
         endcase
      end
   end

   always_comb begin
      rq_wptr_d = rq_wptr_q;
      rq_rptr_d = rq_rptr_q;
      rq_cnt_d  = rq_cnt_q;
      if (rq_push) rq_wptr_d = rq_wptr_q + RqPtrW'(1);
      if (rq_pop)  rq_rptr_d = rq_rptr_q + RqPtrW'(1);
      case ({rq_push, rq_pop})
         2'b10:   rq_cnt_d = rq_cnt_q + (RqPtrW+1)'(1);
         2'b01:   rq_cnt_d = rq_cnt_q - (RqPtrW+1)'(1);
         default: rq_cnt_d = rq_cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iq_wptr_q  <= '0;
         iq_rptr_q  <= '0;
         iq_cnt_q   <= '0;
         rq_wptr_q  <= '0;
         rq_rptr_q  <= '0;
         rq_cnt_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         iq_wptr_q  <= iq_wptr_d;
         iq_rptr_q  <= iq_rptr_d;
         iq_cnt_q   <= iq_cnt_d;
         rq_wptr_q  <= rq_wptr_d;
         rq_rptr_q  <= rq_rptr_d;
         rq_cnt_q   <= rq_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   // Payload storage needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk_i) begin
      if (iq_push) begin
         iq_op_q[iq_wptr_q]   <= req_opcode_i;
         iq_rs_q[iq_wptr_q]   <= req_rs_i;
         iq_rd_q[iq_wptr_q]   <= req_rd_i;
         iq_imm_q[iq_wptr_q]  <= req_imm_i;
         iq_id_q[iq_wptr_q]   <= req_id_i;
         iq_hart_q[iq_wptr_q] <= req_hartid_i;
      end
      if (rq_push) begin
         rq_data_q[rq_wptr_q] <= alu_result_i;
         rq_rd_q[rq_wptr_q]   <= alu_rd_i;
         rq_we_q[rq_wptr_q]   <= alu_we_i;
         rq_id_q[rq_wptr_q]   <= alu_id_i;
         rq_hart_q[rq_wptr_q] <= alu_hartid_i;
      end
   end

   always_comb begin
      alu_opcode_o = IDLE_OP;
      alu_rs_o     = '0;
      alu_rd_o     = '0;
      alu_imm_o    = '0;
      alu_id_o     = '0;
      alu_hartid_o = '0;
      if (issue) begin
         alu_opcode_o = iq_op_q[iq_rptr_q];
         alu_rs_o     = iq_rs_q[iq_rptr_q];
         alu_rd_o     = iq_rd_q[iq_rptr_q];
         alu_imm_o    = iq_imm_q[iq_rptr_q];
         alu_id_o     = iq_id_q[iq_rptr_q];
         alu_hartid_o = iq_hart_q[iq_rptr_q];
      end
   end

   always_comb begin
      res_valid_o  = !rq_empty;
      res_data_o   = '0;
      res_rd_o     = '0;
      res_we_o     = 1'b0;
      res_id_o     = '0;
      res_hartid_o = '0;
      if (!rq_empty) begin
         res_data_o   = rq_data_q[rq_rptr_q];
         res_rd_o     = rq_rd_q[rq_rptr_q];
         res_we_o     = rq_we_q[rq_rptr_q];
         res_id_o     = rq_id_q[rq_rptr_q];
         res_hartid_o = rq_hart_q[rq_rptr_q];
      end
   end

   rq_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(rq_push && rq_full));

endmodule

// File: tb/tb_copro_issue_sched.sv
// Bench for copro_issue_sched: a stand-in single-cycle ALU plus directed and random scenarios
// scored against an acceptance-order result queue.
module tb_copro_issue_sched;

   localparam logic [3:0] IDLE = 4'hF;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic [3:0]  id;
      logic        hart;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_opcode = '0;
   logic [63:0] req_rs = '0;
   logic [4:0]  req_rd = '0;
   logic [5:0]  req_imm = '0;
   logic [3:0]  req_id = '0;
   logic        req_hart = 1'b0;
   logic [3:0]  alu_opcode;
   logic [63:0] alu_rs;
   logic [4:0]  alu_rd_o;
   logic [5:0]  alu_imm;
   logic [3:0]  alu_id_o;
   logic        alu_hart_o;
   logic        alu_valid;
   logic [31:0] alu_result;
   logic [4:0]  alu_rd;
   logic        alu_we;
   logic [3:0]  alu_id;
   logic        alu_hart;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        res_we;
   logic [3:0]  res_id;
   logic        res_hart;
   logic        busy;
   logic        drop;
   logic        spur = 1'b0;

   int   errors = 0;
   int   checks = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   copro_issue_sched dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_opcode_i(req_opcode),
      .req_rs_i(req_rs), .req_rd_i(req_rd), .req_imm_i(req_imm), .req_id_i(req_id),
      .req_hartid_i(req_hart),
      .alu_opcode_o(alu_opcode), .alu_rs_o(alu_rs), .alu_rd_o(alu_rd_o), .alu_imm_o(alu_imm),
      .alu_id_o(alu_id_o), .alu_hartid_o(alu_hart_o),
      .alu_valid_i(alu_valid), .alu_result_i(alu_result), .alu_rd_i(alu_rd), .alu_we_i(alu_we),
      .alu_id_i(alu_id), .alu_hartid_i(alu_hart),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
      .res_rd_o(res_rd), .res_we_o(res_we), .res_id_o(res_id), .res_hartid_o(res_hart),
      .busy_o(busy), .drop_o(drop)
   );

   // Opcodes 0..6 are legal (6 = NOP, we=0); anything else yields no valid.
   function automatic logic legal(input logic [3:0] op);
      return op <= 4'd6;
   endfunction

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [5:0] imm);
      logic [63:0] t;
      t = {a, a} >> imm[4:0];
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return t[31:0];
         default: return 32'd0;
      endcase
   endfunction

   function automatic res_t expect_of(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] rd,
                                      input logic [5:0] imm, input logic [3:0] id, input logic h);
      res_t r;
      r.data = alu_f(op, a, b, imm);
      r.rd   = rd;
      r.we   = (op != 4'd6);
      r.id   = id;
      r.hart = h;
      return r;
   endfunction

   // Stand-in ALU: registered, one-cycle; optionally fires a spurious valid while idle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_valid  <= 1'b0;
         alu_result <= '0;
         alu_rd     <= '0;
         alu_we     <= 1'b0;
         alu_id     <= '0;
         alu_hart   <= 1'b0;
      end else begin
         alu_valid  <= legal(alu_opcode) || (spur && alu_opcode == IDLE);
         alu_result <= alu_f(alu_opcode, alu_rs[31:0], alu_rs[63:32], alu_imm);
         alu_rd     <= alu_rd_o;
         alu_we     <= (alu_opcode != 4'd6);
         alu_id     <= alu_id_o;
         alu_hart   <= alu_hart_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [5:0] imm, input logic [3:0] id,
                            input logic h);
      req_valid  = 1'b1;
      req_opcode = op;
      req_rs     = {b, a};
      req_rd     = rd;
      req_imm    = imm;
      req_id     = id;
      req_hart   = h;
   endtask

   task automatic settle();
      req_valid = 1'b0;
      flush     = 1'b0;
      res_ready = 1'b1;
      repeat (8) tick();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (req_ready !== 1'b1 || alu_opcode !== IDLE || alu_rs !== '0 || alu_id_o !== '0) begin
         errors++;
         $display("FAIL reset_issue: ready=%b op=%h rs=%h id=%h, want 1 F 0 0",
                  req_ready, alu_opcode, alu_rs, alu_id_o);
      end
      checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || busy !== 1'b0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_result: valid=%b data=%h busy=%b drop=%b, want all 0",
                  res_valid, res_data, busy, drop);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ADD 5+7 accepted in cycle 0: issued in 1, result visible in 3.
   task automatic single_latency(input string tag);
      tick();
      drive_req(4'd0, 32'd5, 32'd7, 5'd3, 6'd0, 4'd1, 1'b0);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_accept: ready=%b want 1", tag, req_ready);
      end
      tick();
      req_valid = 1'b0;
      #1;
      checks++;
      if (alu_opcode !== 4'd0 || alu_rd_o !== 5'd3 || alu_rs !== {32'd7, 32'd5}) begin
         errors++;
         $display("FAIL %s_issue: op=%h rd=%0d rs=%h want 0 3 0000000700000005",
                  tag, alu_opcode, alu_rd_o, alu_rs);
      end
      tick();
      #1;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_early: res_valid=%b at cycle 2, want 0", tag, res_valid);
      end
      tick();
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd12 || res_rd !== 5'd3 || res_we !== 1'b1 ||
          res_id !== 4'd1) begin
         errors++;
         $display("FAIL %s_result: v=%b data=%0d rd=%0d we=%b id=%0d want 1 12 3 1 1",
                  tag, res_valid, res_data, res_rd, res_we, res_id);
      end
   endtask

   task automatic test_single();
      single_latency("single");
      settle();
   endtask

   task automatic test_back_to_back();
      int got = 0;
      res_t e, a;
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         req_valid = 1'b0;
         if (c < 4) begin
            logic [3:0]  op = 4'($urandom_range(0, 5));
            logic [31:0] x = $urandom, y = $urandom;
            logic [5:0]  im = 6'($urandom);
            drive_req(op, x, y, 5'(c + 8), im, 4'(c), 1'b1);
            exp_q.push_back(expect_of(op, x, y, 5'(c + 8), im, 4'(c), 1'b1));
         end
         #1;
         if (c < 4) begin
            checks++;
            if (req_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready: cycle %0d ready=%b want 1", c, req_ready);
            end
         end
         if (res_valid) begin
            a = {res_data, res_rd, res_we, res_id, res_hart};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (a !== e || c != 3 + got) begin
               errors++;
               $display("FAIL b2b_result: cycle %0d got %h want %h at cycle %0d", c, a, e, 3 + got);
            end
            got++;
         end
      end
      checks++;
      if (got != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d results want 4", got);
      end
      settle();
   endtask

   task automatic test_backpressure();
      int   sent = 0;
      int   got = 0;
      res_t e, a;
      res_ready = 1'b0;
      for (int c = 0; c < 20 && sent < 6; c++) begin
         tick();
         if (!req_valid) begin
            logic [3:0]  op = 4'($urandom_range(0, 6));
            logic [31:0] x = $urandom, y = $urandom;
            drive_req(op, x, y, 5'(sent), 6'd9, 4'(sent), 1'b0);
            e = expect_of(op, x, y, 5'(sent), 6'd9, 4'(sent), 1'b0);
         end
         #1;
         if (req_ready) begin
            exp_q.push_back(e);
            sent++;
            tick();
            req_valid = 1'b0;
            #1;
         end
      end
      repeat (3) tick();
      checks++;
      if (sent != 6 || req_ready !== 1'b0 || alu_opcode !== IDLE || res_valid !== 1'b1 ||
          busy !== 1'b1) begin
         errors++;
         $display("FAIL bp_full: sent=%0d ready=%b op=%h rv=%b busy=%b want 6 0 F 1 1",
                  sent, req_ready, alu_opcode, res_valid, busy);
      end
      res_ready = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         if (res_valid) begin
            a = {res_data, res_rd, res_we, res_id, res_hart};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL bp_drain: result %0d got %h want %h", got, a, e);
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 6 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: drained %0d busy=%b want 6 0", got, busy);
      end
      settle();
   endtask

   task automatic test_flush();
      int   issues = 0;
      int   got = 0;
      bit   flush_next = 0;
      res_t e, a;
      res_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         req_valid = 1'b0;
         flush = flush_next;
         flush_next = 0;
         if (c < 4) begin
            logic [31:0] x = $urandom, y = $urandom;
            drive_req(4'd4, x, y, 5'(c + 20), 6'd0, 4'(c), 1'b0);
            if (c < 2) exp_q.push_back(expect_of(4'd4, x, y, 5'(c + 20), 6'd0, 4'(c), 1'b0));
         end
         #1;
         if (flush) begin
            checks++;
            if (req_ready !== 1'b0 || alu_opcode !== IDLE || drop !== 1'b0) begin
               errors++;
               $display("FAIL flush_cycle: ready=%b op=%h drop=%b want 0 F 0",
                        req_ready, alu_opcode, drop);
            end
         end
         if (alu_opcode !== IDLE) begin
            issues++;
            if (issues == 3) flush_next = 1;
         end
         if (res_valid) begin
            a = {res_data, res_rd, res_we, res_id, res_hart};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (a !== e || got >= 2) begin
               errors++;
               $display("FAIL flush_result: result %0d got %h want %h", got, a, e);
            end
            got++;
         end
      end
      checks++;
      if (got != 2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_after: delivered %0d busy=%b want 2 0", got, busy);
      end
      settle();
   endtask

   task automatic test_drop();
      int   drops = 0;
      int   drop_cyc = -1;
      int   got = 0;
      res_t e, a;
      res_ready = 1'b1;
      e = expect_of(4'd0, 32'd100, 32'd23, 5'd7, 6'd0, 4'd6, 1'b1);
      for (int c = 0; c < 8; c++) begin
         tick();
         req_valid = 1'b0;
         if (c == 0) drive_req(4'($urandom_range(7, 14)), 32'd1, 32'd2, 5'd9, 6'd0, 4'd5, 1'b0);
         if (c == 1) drive_req(4'd0, 32'd100, 32'd23, 5'd7, 6'd0, 4'd6, 1'b1);
         #1;
         if (drop) begin
            drops++;
            drop_cyc = c;
         end
         if (res_valid) begin
            a = {res_data, res_rd, res_we, res_id, res_hart};
            checks++;
            if (a !== e || c != 4) begin
               errors++;
               $display("FAIL drop_next: cycle %0d got %h want %h at cycle 4", c, a, e);
            end
            got++;
         end
      end
      checks++;
      if (drops != 1 || drop_cyc != 2 || got != 1) begin
         errors++;
         $display("FAIL drop_pulse: drops=%0d at cycle %0d results=%0d want 1 2 1",
                  drops, drop_cyc, got);
      end
      settle();
   endtask

   task automatic test_reset_mid();
      int sent = 0;
      res_ready = 1'b0;
      for (int c = 0; c < 20 && sent < 5; c++) begin
         tick();
         drive_req(4'd1, $urandom, $urandom, 5'd1, 6'd0, 4'(sent), 1'b0);
         #1;
         if (req_ready) sent++;
      end
      tick();
      req_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || alu_opcode !== IDLE || res_valid !== 1'b0 ||
          res_data !== '0 || busy !== 1'b0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: ready=%b op=%h rv=%b data=%h busy=%b drop=%b",
                  req_ready, alu_opcode, res_valid, res_data, busy, drop);
      end
      res_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      single_latency("midreset");
      settle();
   endtask

   task automatic test_random();
      int   acc = 0;
      int   del = 0;
      int   drp = 0;
      int   illegal = 0;
      bit   last_acc = 0;
      bit   cur_legal = 0;
      res_t cur_e, e, a;
      spur = 1'b1;
      for (int c = 0; c < 430; c++) begin
         tick();
         if (last_acc) req_valid = 1'b0;
         last_acc = 0;
         if (c < 400 && !req_valid && ($urandom % 4 != 0)) begin
            logic [3:0]  op = 4'($urandom_range(0, 14));
            logic [31:0] x = $urandom, y = $urandom;
            logic [4:0]  rd = 5'($urandom);
            logic [5:0]  im = 6'($urandom);
            logic [3:0]  id = 4'(acc);
            logic        h = 1'($urandom);
            drive_req(op, x, y, rd, im, id, h);
            cur_e = expect_of(op, x, y, rd, im, id, h);
            cur_legal = legal(op);
         end
         res_ready = (c >= 400) || ($urandom % 4 != 0);
         #1;
         checks++;
         if (busy !== ((acc - del - drp) > 0)) begin
            errors++;
            $display("FAIL rand_busy: cycle %0d busy=%b outstanding=%0d", c, busy, acc - del - drp);
         end
         if (drop) drp++;
         if (res_valid && res_ready) begin
            a = {res_data, res_rd, res_we, res_id, res_hart};
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL rand_result: cycle %0d got %h want %h", c, a, e);
            end
            del++;
         end
         if (req_valid && req_ready) begin
            acc++;
            last_acc = 1;
            if (cur_legal) exp_q.push_back(cur_e);
            else illegal++;
         end
      end
      checks++;
      if (exp_q.size() != 0 || drp != illegal || busy !== 1'b0 || acc == 0) begin
         errors++;
         $display("FAIL rand_end: left=%0d drops=%0d illegal=%0d busy=%b accepted=%0d",
                  exp_q.size(), drp, illegal, busy, acc);
      end
      spur = 1'b0;
      settle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
